adc_udp_packetizer_mc: RTL and testbench
========================================

Name: adc_udp_packetizer_mc

Overview:
Multi-channel successor to the single-stream ADC-to-UDP packetizer. It buffers NUM_CH independent ADC sample streams in per-channel FWFT FIFOs. Round-robin arbitration picks among channels holding a full payload. Each packet is a header word followed by a runtime-configurable number of payload words, driven onto one AXIS master toward the UDP/10G MAC path. All logic runs on one clock domain; CDC from ADC clocks is done upstream.

Parameters:
NUM_CH, 4, number of input channels (1..16)
TDATA_WIDTH, 64, input and output data width in bits (≥64; header is zero-extended above bit 63)
FIFO_DEPTH, 512, words per channel FIFO (power of 2)
MAX_PAYLOAD, 256, upper bound on cfg_payload_words (≤ FIFO_DEPTH)
HDR_MAGIC, 16'hADC5, header bits [63:48]

Ports:
s00_axi_aclk  in  1  sole clock
m00_axis_aresetn  in  1  reset
cfg_enable  in  1  packetizer enable (quasi-static, from register file)
cfg_payload_words  in  16  payload words per packet
s_axis_tvalid  in  NUM_CH  per-channel valid
s_axis_tdata  in  NUM_CH*TDATA_WIDTH  channel k at [k*W +: W]
s_axis_tready  out  NUM_CH  per-channel ready
m00_axis_tvalid  out  1  output valid
m00_axis_tdata  out  TDATA_WIDTH  output data
m00_axis_tkeep  out  TDATA_WIDTH/8  byte enables
m00_axis_tlast  out  1  last word of packet
m00_axis_tuser  out  1  on the header word: overflow occurred on that channel since its previous packet
m00_axis_tready  in  1  downstream ready
overflow_count  out  32  total dropped input beats, saturating
pkt_count  out  32  total packets completed, wrapping

Behaviour:
- Reset: m00_axis_aresetn, asynchronous, active-high. Clock: s00_axi_aclk.
- While reset is asserted:
  - m00_axis_tvalid, tlast, tuser = 0; tdata = 0; tkeep = all ones.
  - s_axis_tready = 0; FIFOs empty; counters = 0; per-channel sequence numbers = 0; round-robin pointer = channel 0.
- Reset mid-packet aborts the packet immediately with no tlast.
- Input:
  - s_axis_tready[k] = !full[k] when cfg_enable = 1, and 1 when cfg_enable = 0.
  - A push happens when tvalid & tready & cfg_enable.
  - tready is derived from full only. A simultaneous pop does not let a push into a full FIFO.
  - If cfg_enable = 1 and tvalid[k] & !tready[k]: the beat is dropped, overflow_count += 1 (saturates at 2^32-1), and sticky ovf[k] is set.
  - Overflow on several channels in one cycle adds the number of offending channels.
- Effective length L = cfg_payload_words, clamped: 0 becomes 1; values > MAX_PAYLOAD become MAX_PAYLOAD. L is latched when a channel is granted.
- Channel k is eligible when cfg_enable = 1 and fifo_count[k] ≥ L.
- FSM states:
  - IDLE: if any channel is eligible, grant the first eligible channel at or after rr_ptr. Register the grant and go to HEADER. The header appears with tvalid on the next cycle (1-cycle latency from eligibility).
  - HEADER:
    - tdata[63:48] = HDR_MAGIC; [47:40] = channel id; [39:32] = {7'b0, ovf[k]}; [31:0] = seq[k].
    - tuser = ovf[k].
    - On tready: ovf[k] is cleared (a new overflow in the same cycle keeps it set), seq[k] += 1 (wraps 2^32-1 → 0), go to PAYLOAD.
  - PAYLOAD:
    - tdata = FIFO[k] head. Pop on tvalid & tready. Word counter runs 0..L-1.
    - tlast = 1 on word L-1. On that handshake: pkt_count += 1, rr_ptr = k+1 mod NUM_CH, go to IDLE.
- IDLE→HEADER gap: at least one cycle between packets.
- AXIS rules: once tvalid is high, tdata, tlast and tuser stay stable until tready. tvalid never drops mid-packet, because eligibility guarantees L words are present.
- cfg_enable falling: the current packet completes normally, then the FSM stays in IDLE. While disabled, all FIFOs are flushed to empty on the cycle after the FSM is in IDLE. Data arriving while disabled is discarded and not counted.
- cfg_payload_words changes mid-packet: no effect until the next grant.
- tkeep is always all ones.

Test Plan:
1. NUM_CH=4, L=8, tready=1; channel 0 sends 8 beats 0x007CB66BA55A0000.. → header 0xADC5_00_00_00000000, then 8 payload words in order with tlast on the 8th; pkt_count=1.
2. All 4 channels pre-loaded with 16 words, L=8 → packets in channel order 0,1,2,3,0,1,2,3; second packet of each channel carries seq=1.
3. m00_axis_tready toggled 0 for 5 cycles mid-payload → tdata held stable, no word lost or duplicated, tvalid stays high.
4. Channel 2 pushed 520 beats with tready=0 and FIFO_DEPTH=512 → s_axis_tready[2]=0 after 512 beats, overflow_count=8; next channel-2 header has bit 32=1 and tuser=1; the following channel-2 header has bit 32=0.
5. cfg_payload_words=0 → 1-word packets; cfg_payload_words=1000 → 256-word packets.
6. Reset asserted mid-payload → outputs zeroed asynchronously; after release the first header has seq=0.

Source files
------------

// File: rtl/adc_udp_packetizer_mc.sv
// adc_udp_packetizer_mc
//   Buffers NUM_CH ADC sample streams in per-channel first-word-fall-through
//   FIFOs and emits UDP-bound packets on one AXIS master: a header word
//   {magic, channel, overflow flag, sequence} followed by L payload words
//   from the granted channel. Channels are granted round-robin once they
//   hold a full payload, so tvalid never drops inside a packet.
//
// Ports
//   s00_axi_aclk       sole clock
//   m00_axis_aresetn   asynchronous reset, active-high
//   cfg_enable         packetizer enable; when low, input is discarded and
//                      the FIFOs are flushed once the FSM is idle
//   cfg_payload_words  payload words per packet (0 -> 1, clamped to MAX_PAYLOAD)
//   s_axis_*           per-channel input streams, channel k at [k*W +: W]
//   m00_axis_*         packet output stream (tuser flags an overflow on the header)
//   overflow_count     dropped input beats, saturating
//   pkt_count          completed packets, wrapping
module adc_udp_packetizer_mc #(
    parameter int          NUM_CH      = 4,
    parameter int          TDATA_WIDTH = 64,
    parameter int          FIFO_DEPTH  = 512,
    parameter int          MAX_PAYLOAD = 256,
    parameter logic [15:0] HDR_MAGIC   = 16'hADC5
) (
    input  logic                        s00_axi_aclk,
    input  logic                        m00_axis_aresetn,
    input  logic                        cfg_enable,
    input  logic [15:0]                 cfg_payload_words,
    input  logic [NUM_CH-1:0]           s_axis_tvalid,
    input  logic [NUM_CH*TDATA_WIDTH-1:0] s_axis_tdata,
    output logic [NUM_CH-1:0]           s_axis_tready,
    output logic                        m00_axis_tvalid,
    output logic [TDATA_WIDTH-1:0]      m00_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]    m00_axis_tkeep,
    output logic                        m00_axis_tlast,
    output logic                        m00_axis_tuser,
    input  logic                        m00_axis_tready,
    output logic [31:0]                 overflow_count,
    output logic [31:0]                 pkt_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t state_q, state_d;

    logic [TDATA_WIDTH-1:0] mem [NUM_CH][FIFO_DEPTH];
    logic [AW:0]            wr_ptr [NUM_CH];
    logic [AW:0]            rd_ptr [NUM_CH];
    logic [AW:0]            count  [NUM_CH];
    logic [31:0]            seq    [NUM_CH];
    logic [NUM_CH-1:0]      ovf, full, push, pop, drop, elig, hdr_done;

    logic [CH_W-1:0] rr_ptr, grant_q, grant_d;
    logic            any_elig;
    logic [15:0]     len_eff, len_q, word_cnt;
    logic [63:0]     hdr_q;
    logic [4:0]      ovf_add;
    logic [32:0]     ovf_sum;
    logic            flush, last_word;

    // Clamp the requested payload length into 1..MAX_PAYLOAD.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        len_eff = cfg_payload_words;
        if (cfg_payload_words == 16'd0)
            len_eff = 16'd1;
        else if (32'(cfg_payload_words) > MAX_PAYLOAD)
            len_eff = 16'(MAX_PAYLOAD);
    end

    assign flush     = !cfg_enable && (state_q == IDLE);
    assign last_word = (word_cnt == len_q - 16'd1);

    // Per-channel FIFO status and handshake decode. Input ready depends on
    // full only, so a pop in the same cycle never admits a push into a full FIFO.
    always_comb begin
        ovf_add = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            count[k]         = wr_ptr[k] - rd_ptr[k];
            full[k]          = (count[k] == FULL_CNT);
            s_axis_tready[k] = m00_axis_aresetn ? 1'b0 : (cfg_enable ? !full[k] : 1'b1);
            push[k]          = cfg_enable && s_axis_tvalid[k] && !full[k];
            drop[k]          = cfg_enable && s_axis_tvalid[k] && full[k];
            elig[k]          = cfg_enable && (32'(count[k]) >= 32'(len_eff));
            pop[k]           = (state_q == PAYLOAD) && m00_axis_tready && (grant_q == CH_W'(k));
            hdr_done[k]      = (state_q == HEADER) && m00_axis_tready && (grant_q == CH_W'(k));
            ovf_add          = ovf_add + 5'(drop[k]);
        end
    end

    // First eligible channel at or after the round-robin pointer.
    always_comb begin
        any_elig = 1'b0;
        grant_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any_elig && elig[(int'(rr_ptr) + i) % NUM_CH]) begin
                any_elig = 1'b1;
                grant_d  = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            end
        end
    end

    // NOTE: sample storage carries no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge s00_axi_aclk) begin
        for (int k = 0; k < NUM_CH; k++)
            if (push[k])
                mem[k][wr_ptr[k][AW-1:0]] <= s_axis_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
    end

    // Per-channel pointers, sticky overflow flags and sequence numbers.
    // A header reports the overflow flag captured at grant; only that
    // reported overflow is cleared, so one arriving while the header waits
    // is carried into the next packet instead of being lost.
    always_ff @(posedge s00_axi_aclk or posedge m00_axis_aresetn) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (m00_axis_aresetn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                seq[k]    <= '0;
            end
            ovf <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (flush) begin
                    rd_ptr[k] <= wr_ptr[k];
                end else begin
                    if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                    if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end
                ovf[k] <= drop[k] | (ovf[k] & ~(hdr_done[k] & hdr_q[32]));
                if (hdr_done[k]) seq[k] <= seq[k] + 32'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge s00_axi_aclk or posedge m00_axis_aresetn) begin
        if (m00_axis_aresetn) state_q <= IDLE;
        else                  state_q <= state_d;
    end

    // FSM next state and AXIS outputs.
    always_comb begin
        state_d         = state_q;
        m00_axis_tvalid = 1'b0;
        m00_axis_tdata  = '0;
        m00_axis_tkeep  = '1;
        m00_axis_tlast  = 1'b0;
        m00_axis_tuser  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) state_d = HEADER;
            end
            HEADER: begin
                m00_axis_tvalid = 1'b1;
                m00_axis_tdata  = TDATA_WIDTH'(hdr_q);
                m00_axis_tuser  = hdr_q[32];
                if (m00_axis_tready) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                m00_axis_tvalid = 1'b1;
                m00_axis_tdata  = mem[grant_q][rd_ptr[grant_q][AW-1:0]];
                m00_axis_tlast  = last_word;
                if (m00_axis_tready && last_word) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant capture, word counter, round-robin pointer and statistics.
    assign ovf_sum = {1'b0, overflow_count} + 33'(ovf_add);

    always_ff @(posedge s00_axi_aclk or posedge m00_axis_aresetn) begin
        if (m00_axis_aresetn) begin
            grant_q        <= '0;
            len_q          <= 16'd1;
            hdr_q          <= '0;
            word_cnt       <= '0;
            rr_ptr         <= '0;
            pkt_count      <= '0;
            overflow_count <= '0;
        end else begin
            overflow_count <= ovf_sum[32] ? 32'hFFFF_FFFF : ovf_sum[31:0];
            if (state_q == IDLE && any_elig) begin
                grant_q <= grant_d;
                len_q   <= len_eff;
                hdr_q   <= {HDR_MAGIC, 8'(grant_d), 7'b0, ovf[grant_d], seq[grant_d]};
            end
            if (state_q == HEADER && m00_axis_tready)
                word_cnt <= '0;
            if (state_q == PAYLOAD && m00_axis_tready) begin
                word_cnt <= word_cnt + 16'd1;
                if (last_word) begin
                    pkt_count <= pkt_count + 32'd1;
                    rr_ptr    <= (int'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_udp_packetizer_mc.sv
// tb_adc_udp_packetizer_mc
//   Directed bench for adc_udp_packetizer_mc (4 channels, 64-bit, 512-deep
//   FIFOs, MAX_PAYLOAD 256). A negedge monitor records every output
//   handshake into a queue and checks that stalled beats hold steady;
//   stimulus drives inputs 1 ns after the rising edge.
module tb_adc_udp_packetizer_mc;

    localparam int NCH = 4;
    localparam int W   = 64;

    logic             s00_axi_aclk = 1'b0;
    logic             m00_axis_aresetn;
    logic             cfg_enable;
    logic [15:0]      cfg_payload_words;
    logic [NCH-1:0]   s_axis_tvalid;
    logic [NCH*W-1:0] s_axis_tdata;
    logic [NCH-1:0]   s_axis_tready;
    logic             m00_axis_tvalid;
    logic [W-1:0]     m00_axis_tdata;
    logic [W/8-1:0]   m00_axis_tkeep;
    logic             m00_axis_tlast;
    logic             m00_axis_tuser;
    logic             m00_axis_tready;
    logic [31:0]      overflow_count;
    logic [31:0]      pkt_count;

    adc_udp_packetizer_mc dut (
        .s00_axi_aclk      (s00_axi_aclk),
        .m00_axis_aresetn  (m00_axis_aresetn),
        .cfg_enable        (cfg_enable),
        .cfg_payload_words (cfg_payload_words),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tready     (s_axis_tready),
        .m00_axis_tvalid   (m00_axis_tvalid),
        .m00_axis_tdata    (m00_axis_tdata),
        .m00_axis_tkeep    (m00_axis_tkeep),
        .m00_axis_tlast    (m00_axis_tlast),
        .m00_axis_tuser    (m00_axis_tuser),
        .m00_axis_tready   (m00_axis_tready),
        .overflow_count    (overflow_count),
        .pkt_count         (pkt_count)
    );

    always #5 s00_axi_aclk = ~s00_axi_aclk;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        user;
    } beat_t;

    beat_t       q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input int ch, input logic ovf, input int sq);
        return {16'hADC5, 8'(ch), 7'b0, ovf, 32'(sq)};
    endfunction

    // Record handshakes; a beat stalled last cycle must still be there unchanged.
    always @(negedge s00_axi_aclk) begin
        if (m00_axis_aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m00_axis_tvalid), 64'd1);
                check("hold_data", m00_axis_tdata, prev_data);
                check("hold_last", 64'(m00_axis_tlast), 64'(prev_last));
            end
            if (m00_axis_tvalid && m00_axis_tready)
                q.push_back('{data: m00_axis_tdata, last: m00_axis_tlast, user: m00_axis_tuser});
            prev_stall = m00_axis_tvalid && !m00_axis_tready;
            prev_data  = m00_axis_tdata;
            prev_last  = m00_axis_tlast;
        end
    end

    task automatic step();
        @(posedge s00_axi_aclk);
        #1;
    endtask

    task automatic do_reset();
        m00_axis_aresetn = 1'b1;
        s_axis_tvalid    = '0;
        repeat (3) step();
        m00_axis_aresetn = 1'b0;
        q.delete();
        step();
    endtask

    task automatic push(input int ch, input logic [63:0] val);
        s_axis_tvalid[ch]         = 1'b1;
        s_axis_tdata[ch*W +: W]   = val;
        step();
        s_axis_tvalid[ch]         = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int cyc = 0;
        while (q.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        check(tag, 64'(q.size() >= n), 64'd1);
    endtask

    // Pops one beat and compares it; an empty queue counts as a failure.
    task automatic expect_beat(input string tag, input logic [63:0] data,
                               input logic last, input logic user);
        beat_t b;
        if (q.size() == 0) begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            b = q.pop_front();
            check({tag, "_data"}, b.data, data);
            check({tag, "_last"}, 64'(b.last), 64'(last));
            check({tag, "_user"}, 64'(b.user), 64'(user));
        end
    endtask

    initial begin
        beat_t b;
        m00_axis_aresetn  = 1'b1;
        cfg_enable        = 1'b1;
        cfg_payload_words = 16'd8;
        s_axis_tvalid     = '0;
        s_axis_tdata      = '0;
        m00_axis_tready   = 1'b1;
        repeat (2) step();

        // Reset state
        check("rst_tvalid", 64'(m00_axis_tvalid), 64'd0);
        check("rst_tdata", m00_axis_tdata, 64'd0);
        check("rst_tkeep", 64'(m00_axis_tkeep), 64'hFF);
        check("rst_tlast", 64'(m00_axis_tlast), 64'd0);
        check("rst_tuser", 64'(m00_axis_tuser), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_ovf_cnt", 64'(overflow_count), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_count), 64'd0);
        m00_axis_aresetn = 1'b0;
        step();

        // 1: single 8-word packet from channel 0
        for (int i = 0; i < 8; i++) push(0, 64'h007C_B66B_A55A_0000 + 64'(i));
        wait_beats("t1_beats", 9, 50);
        expect_beat("t1_hdr", 64'hADC5_0000_0000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            expect_beat("t1_pay", 64'h007C_B66B_A55A_0000 + 64'(i), i == 7, 1'b0);
        check("t1_pkt_cnt", 64'(pkt_count), 64'd1);

        // 2: all channels preloaded with 16 words, round-robin order
        do_reset();
        m00_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_axis_tvalid = '1;
            for (int k = 0; k < NCH; k++) s_axis_tdata[k*W +: W] = 64'hC000_0000_0000_0000 | 64'(k << 16) | 64'(i);
            step();
        end
        s_axis_tvalid   = '0;
        m00_axis_tready = 1'b1;
        wait_beats("t2_beats", 72, 200);
        for (int p = 0; p < 8; p++) begin
            expect_beat("t2_hdr", hdr(p % 4, 1'b0, p / 4), 1'b0, 1'b0);
            for (int j = 0; j < 8; j++)
                expect_beat("t2_pay", 64'hC000_0000_0000_0000 | 64'((p % 4) << 16) | 64'((p / 4) * 8 + j),
                            j == 7, 1'b0);
        end
        check("t2_pkt_cnt", 64'(pkt_count), 64'd8);

        // 3: downstream stall of 5 cycles mid-payload
        do_reset();
        for (int i = 0; i < 8; i++) push(1, 64'h3300 + 64'(i));
        wait_beats("t3_pre", 4, 50);
        m00_axis_tready = 1'b0;
        repeat (5) step();
        m00_axis_tready = 1'b1;
        wait_beats("t3_beats", 9, 50);
        repeat (5) step();
        check("t3_count", 64'(q.size()), 64'd9);
        expect_beat("t3_hdr", hdr(1, 1'b0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) expect_beat("t3_pay", 64'h3300 + 64'(i), i == 7, 1'b0);

        // 4: channel 2 overflows while the output is blocked
        do_reset();
        m00_axis_tready = 1'b0;
        for (int i = 0; i < 520; i++) begin
            s_axis_tvalid[2]      = 1'b1;
            s_axis_tdata[2*W +: W] = 64'(i);
            if (i == 511) check("t4_ready_511", 64'(s_axis_tready[2]), 64'd1);
            if (i == 512) check("t4_ready_512", 64'(s_axis_tready[2]), 64'd0);
            step();
        end
        s_axis_tvalid = '0;
        step();
        check("t4_ovf_cnt", 64'(overflow_count), 64'd8);
        m00_axis_tready = 1'b1;
        wait_beats("t4_beats", 27, 100);
        // First packet was granted before the overflow; only its seq/fields are checked.
        b = q.pop_front();
        check("t4_h1", b.data & ~64'h1_0000_0000, hdr(2, 1'b0, 0));
        for (int j = 0; j < 8; j++) expect_beat("t4_p1", 64'(j), j == 7, 1'b0);
        expect_beat("t4_h2", hdr(2, 1'b1, 1), 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) expect_beat("t4_p2", 64'(8 + j), j == 7, 1'b0);
        expect_beat("t4_h3", hdr(2, 1'b0, 2), 1'b0, 1'b0);

        // 5: length clamping, 0 -> 1 and 1000 -> 256
        do_reset();
        cfg_payload_words = 16'd0;
        push(3, 64'h55);
        push(3, 64'h66);
        wait_beats("t5a_beats", 4, 50);
        expect_beat("t5a_h0", hdr(3, 1'b0, 0), 1'b0, 1'b0);
        expect_beat("t5a_p0", 64'h55, 1'b1, 1'b0);
        expect_beat("t5a_h1", hdr(3, 1'b0, 1), 1'b0, 1'b0);
        expect_beat("t5a_p1", 64'h66, 1'b1, 1'b0);
        cfg_payload_words = 16'd1000;
        for (int i = 0; i < 256; i++) push(0, 64'h1000 + 64'(i));
        wait_beats("t5b_beats", 257, 400);
        expect_beat("t5b_hdr", hdr(0, 1'b0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) expect_beat("t5b_pay", 64'h1000 + 64'(i), i == 255, 1'b0);
        check("t5_pkt_cnt", 64'(pkt_count), 64'd3);
        cfg_payload_words = 16'd8;

        // 6: reset asserted mid-payload
        do_reset();
        for (int i = 0; i < 8; i++) push(0, 64'h600 + 64'(i));
        wait_beats("t6_pre", 4, 50);
        #2;
        m00_axis_aresetn = 1'b1;
        #1;
        check("t6_tvalid", 64'(m00_axis_tvalid), 64'd0);
        check("t6_tdata", m00_axis_tdata, 64'd0);
        check("t6_tlast", 64'(m00_axis_tlast), 64'd0);
        check("t6_tkeep", 64'(m00_axis_tkeep), 64'hFF);
        check("t6_s_tready", 64'(s_axis_tready), 64'd0);
        repeat (3) step();
        m00_axis_aresetn = 1'b0;
        q.delete();
        step();
        for (int i = 0; i < 8; i++) push(0, 64'h700 + 64'(i));
        wait_beats("t6_beats", 9, 50);
        expect_beat("t6_hdr", hdr(0, 1'b0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) expect_beat("t6_pay", 64'h700 + 64'(i), i == 7, 1'b0);

        // 7: disabling flushes partial FIFO contents and discards input
        for (int i = 0; i < 4; i++) push(1, 64'hA0 + 64'(i));
        cfg_enable = 1'b0;
        repeat (3) step();
        check("t7_s_tready", 64'(s_axis_tready), 64'hF);
        push(1, 64'hDD);
        cfg_enable = 1'b1;
        for (int i = 0; i < 4; i++) push(1, 64'hB0 + 64'(i));
        repeat (20) step();
        check("t7_no_pkt", 64'(q.size()), 64'd0);
        for (int i = 0; i < 4; i++) push(1, 64'hC0 + 64'(i));
        wait_beats("t7_beats", 9, 50);
        expect_beat("t7_hdr", hdr(1, 1'b0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            expect_beat("t7_pay", (i < 4) ? 64'hB0 + 64'(i) : 64'hC0 + 64'(i - 4), i == 7, 1'b0);
        check("t7_ovf_cnt", 64'(overflow_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
